// File: rtl/reg_file_wb_pkg.sv
// Shared constants for the register file / write-back stage. The instruction
// decoder uses the same widths, so they live in one place.
package reg_file_wb_pkg;

    localparam int RF_DATA_W   = 8;
    localparam int RF_ADDR_W   = 3;
    localparam int RF_NUM_REGS = 1 << RF_ADDR_W;

endpackage

// File: rtl/reg_file_wb_if.sv
// Bus between the decoder/write-request FSM side (master) and the register
// file (slave).
//
// Signal semantics: wr_addr is only meaningful while wr_req=1, and wr_data is
// only meaningful while wr_en=1. There is no ready/back-pressure. A wr_req
// that cannot be taken is reported through the one-cycle wr_drop pulse. A
// wr_en that does not line up with a pending address is reported through the
// one-cycle wr_err pulse. Read data and hazard flags are combinational in the
// same cycle as the read address.
interface reg_file_wb_if
    import reg_file_wb_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              hazard_a;
    logic              hazard_b;
    logic              wr_pending;
    logic              wr_drop;
    logic              wr_err;

    modport master (
        output wr_req, wr_addr, wr_en, wr_data, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, hazard_a, hazard_b,
               wr_pending, wr_drop, wr_err
    );

    modport slave (
        input  wr_req, wr_addr, wr_en, wr_data, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, hazard_a, hazard_b,
               wr_pending, wr_drop, wr_err
    );
endinterface

// File: rtl/reg_file_wb_wr_addr_pipe.sv
// Two-stage destination-address pipe. Stage 1 is occupied exactly while the
// upstream write-request FSM sits in its delay state, so a request arriving
// then is dropped here just as the FSM ignores it.
module wr_addr_pipe
    import reg_file_wb_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              v1,
    output logic [ADDR_W-1:0] a1,
    output logic              v2,
    output logic [ADDR_W-1:0] a2,
    output logic              wr_drop
);

    logic              v1_q, v1_d;
    logic [ADDR_W-1:0] a1_q, a1_d;
    logic              v2_q, v2_d;
    logic [ADDR_W-1:0] a2_q, a2_d;
    logic              drop_q, drop_d;
    logic              accept;

    // Next state: accept into stage 1 when empty, always shift stage 1 to 2.
    always_comb begin
        accept = wr_req & ~v1_q;
        v1_d   = accept;
        a1_d   = accept ? wr_addr : a1_q;
        v2_d   = v1_q;
        a2_d   = a1_q;
        drop_d = wr_req & v1_q;
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            v1_q   <= 1'b0;
            a1_q   <= '0;
            v2_q   <= 1'b0;
            a2_q   <= '0;
            drop_q <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            a1_q   <= a1_d;
            v2_q   <= v2_d;
            a2_q   <= a2_d;
            drop_q <= drop_d;
        end
    end

    assign v1      = v1_q;
    assign a1      = a1_q;
    assign v2      = v2_q;
    assign a2      = a2_q;
    assign wr_drop = drop_q;

endmodule

// File: rtl/reg_file_wb.sv
// Register file with write-back alignment. The destination address is delayed
// two cycles to meet the delayed write strobe, then committed. Two read ports
// bypass the write being committed this cycle; a read of the address still in
// stage 1 is flagged as a hazard because its data does not exist yet.
module reg_file_wb
    import reg_file_wb_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic          clk,
    input  logic          rst_b,
    reg_file_wb_if.slave  bus
);

    localparam int NUM_REGS = 1 << ADDR_W;

    logic              v1, v2;
    logic [ADDR_W-1:0] a1, a2;
    logic              drop;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              err_q, err_d;
    logic              commit;

    wr_addr_pipe #(
        .ADDR_W (ADDR_W)
    ) u_pipe (
        .clk     (clk),
        .rst_b   (rst_b),
        .wr_req  (bus.wr_req),
        .wr_addr (bus.wr_addr),
        .v1      (v1),
        .a1      (a1),
        .v2      (v2),
        .a2      (a2),
        .wr_drop (drop)
    );

    // Commit the strobed data only when the address pipe agrees; flag any
    // disagreement between strobe and pipe.
    always_comb begin
        commit = bus.wr_en & v2;
        err_d  = bus.wr_en ^ v2;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (commit) begin
            regs_d[a2] = bus.wr_data;
        end
    end

    // Register array and error pulse; reset wins over a same-cycle commit.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            err_q <= err_d;
        end
    end

    // Read ports with bypass of the committing write, plus hazard/status.
    always_comb begin
        if (commit && (bus.rd_addr_a == a2)) begin
            bus.rd_data_a = bus.wr_data;
        end else begin
            bus.rd_data_a = regs_q[bus.rd_addr_a];
        end
        if (commit && (bus.rd_addr_b == a2)) begin
            bus.rd_data_b = bus.wr_data;
        end else begin
            bus.rd_data_b = regs_q[bus.rd_addr_b];
        end
        bus.hazard_a   = v1 & (bus.rd_addr_a == a1);
        bus.hazard_b   = v1 & (bus.rd_addr_b == a1);
        bus.wr_pending = v1 | v2;
        bus.wr_drop    = drop;
        bus.wr_err     = err_q;
    end

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed scenarios plus a random phase,
// all checked against a bench-side behavioural model through an expected queue.
module tb_reg_file_wb;

    logic clk;
    logic rst_b;

    reg_file_wb_if bus ();

    reg_file_wb dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state
    logic [20:0] exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    // Behavioural model state
    logic [7:0] m_regs [8];
    logic       m_v1, m_v2, m_drop, m_err;
    logic [2:0] m_a1, m_a2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs for the current model state and the inputs just driven.
    function automatic logic [20:0] model_out(input logic en, input logic [7:0] data,
                                              input logic [2:0] ra, input logic [2:0] rb);
        logic [7:0] ea, eb;
        ea = m_regs[ra];
        eb = m_regs[rb];
        if (en && m_v2 && ra == m_a2) ea = data;
        if (en && m_v2 && rb == m_a2) eb = data;
        return {ea, eb, m_v1 && ra == m_a1, m_v1 && rb == m_a1,
                m_v1 || m_v2, m_drop, m_err};
    endfunction

    // Advance the model across one rising edge.
    task automatic model_step(input logic req, input logic [2:0] addr, input logic en,
                              input logic [7:0] data, input logic rstb);
        logic busy, pend_ok;
        busy    = m_v1;
        pend_ok = m_v2;
        if (!rstb) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
            m_v1 = 0; m_v2 = 0; m_a1 = 0; m_a2 = 0; m_drop = 0; m_err = 0;
        end else begin
            if (en && pend_ok) m_regs[m_a2] = data;
            m_err  = en != pend_ok;
            m_drop = req && busy;
            m_v2   = busy;
            m_a2   = m_a1;
            m_v1   = req && !busy;
            if (req && !busy) m_a1 = addr;
        end
    endtask

    // Driver: one clock cycle of stimulus, scoreboard push/pop and compare.
    task automatic cyc(input logic req, input logic [2:0] addr, input logic en,
                       input logic [7:0] data, input logic [2:0] ra, input logic [2:0] rb,
                       input logic rstb);
        logic [20:0] e;
        @(posedge clk);
        #1;
        rst_b         = rstb;
        bus.wr_req    = req;
        bus.wr_addr   = addr;
        bus.wr_en     = en;
        bus.wr_data   = data;
        bus.rd_addr_a = ra;
        bus.rd_addr_b = rb;
        exp_q.push_back(model_out(en, data, ra, rb));
        @(negedge clk);
        e = exp_q.pop_front();
        check("rd_data_a",  {24'h0, bus.rd_data_a}, {24'h0, e[20:13]});
        check("rd_data_b",  {24'h0, bus.rd_data_b}, {24'h0, e[12:5]});
        check("hazard_a",   {31'h0, bus.hazard_a},   {31'h0, e[4]});
        check("hazard_b",   {31'h0, bus.hazard_b},   {31'h0, e[3]});
        check("wr_pending", {31'h0, bus.wr_pending}, {31'h0, e[2]});
        check("wr_drop",    {31'h0, bus.wr_drop},    {31'h0, e[1]});
        check("wr_err",     {31'h0, bus.wr_err},     {31'h0, e[0]});
        model_step(req, addr, en, data, rstb);
    endtask

    initial begin
        rst_b = 1'b0;
        bus.wr_req = 0; bus.wr_addr = 0; bus.wr_en = 0; bus.wr_data = 0;
        bus.rd_addr_a = 0; bus.rd_addr_b = 0;
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_v1 = 0; m_v2 = 0; m_a1 = 0; m_a2 = 0; m_drop = 0; m_err = 0;

        // Reset for two cycles, then read every address.
        cyc(0, 0, 0, 8'h00, 0, 0, 0);
        cyc(0, 0, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 8'h00, 3'(2 * i), 3'(2 * i + 1), 1);
            check("rst_rd_a", {24'h0, bus.rd_data_a}, 32'h0);
            check("rst_rd_b", {24'h0, bus.rd_data_b}, 32'h0);
            check("rst_pend", {31'h0, bus.wr_pending}, 32'h0);
            check("rst_flags", {29'h0, bus.hazard_a, bus.wr_drop, bus.wr_err}, 32'h0);
        end

        // Single write to r5 with 0xA5.
        cyc(1, 5, 0, 8'h00, 5, 0, 1);
        cyc(0, 0, 0, 8'h00, 5, 0, 1);
        check("single_hazard", {31'h0, bus.hazard_a}, 32'h1);
        cyc(0, 0, 1, 8'hA5, 5, 0, 1);
        check("single_bypass", {24'h0, bus.rd_data_a}, 32'hA5);
        check("single_nohaz", {31'h0, bus.hazard_a}, 32'h0);
        cyc(0, 0, 0, 8'h00, 5, 5, 1);
        check("single_stored", {24'h0, bus.rd_data_b}, 32'hA5);

        // Back-to-back: second request dropped, third accepted.
        cyc(1, 2, 0, 8'h00, 2, 3, 1);
        cyc(1, 3, 0, 8'h00, 2, 3, 1);
        cyc(1, 3, 1, 8'h22, 2, 3, 1);
        check("b2b_drop", {31'h0, bus.wr_drop}, 32'h1);
        cyc(0, 0, 0, 8'h00, 2, 3, 1);
        check("b2b_r2", {24'h0, bus.rd_data_a}, 32'h22);
        check("b2b_r3_old", {24'h0, bus.rd_data_b}, 32'h00);
        cyc(0, 0, 1, 8'h33, 2, 3, 1);
        check("b2b_r3_byp", {24'h0, bus.rd_data_b}, 32'h33);
        cyc(0, 0, 0, 8'h00, 3, 2, 1);
        check("b2b_r3", {24'h0, bus.rd_data_a}, 32'h33);

        // Misalignment: stray strobe, then a missing strobe.
        cyc(0, 0, 1, 8'hFF, 0, 7, 1);
        cyc(0, 0, 0, 8'h00, 0, 7, 1);
        check("mis_stray_err", {31'h0, bus.wr_err}, 32'h1);
        check("mis_stray_r0", {24'h0, bus.rd_data_a}, 32'h00);
        cyc(1, 7, 0, 8'h00, 0, 7, 1);
        cyc(0, 0, 0, 8'h00, 0, 7, 1);
        cyc(0, 0, 0, 8'h77, 0, 7, 1);
        cyc(0, 0, 0, 8'h00, 0, 7, 1);
        check("mis_miss_err", {31'h0, bus.wr_err}, 32'h1);
        check("mis_miss_r7", {24'h0, bus.rd_data_b}, 32'h00);

        // Dual read: r1 = 0x5A, then two writes to r6 read on both ports.
        cyc(1, 1, 0, 8'h00, 0, 0, 1);
        cyc(0, 0, 0, 8'h00, 0, 0, 1);
        cyc(1, 6, 1, 8'h5A, 0, 0, 1);
        cyc(0, 0, 0, 8'h00, 6, 6, 1);
        cyc(0, 0, 1, 8'h3C, 6, 6, 1);
        check("dual_a", {24'h0, bus.rd_data_a}, 32'h3C);
        check("dual_b", {24'h0, bus.rd_data_b}, 32'h3C);
        cyc(1, 6, 0, 8'h00, 6, 1, 1);
        cyc(0, 0, 0, 8'h00, 6, 1, 1);
        cyc(0, 0, 1, 8'hC3, 6, 1, 1);
        check("dual2_a", {24'h0, bus.rd_data_a}, 32'hC3);
        check("dual2_b_r1", {24'h0, bus.rd_data_b}, 32'h5A);

        // Reset mid-flight discards the in-flight write to r4.
        cyc(1, 4, 0, 8'h00, 4, 6, 1);
        cyc(0, 0, 0, 8'h00, 4, 6, 0);
        cyc(0, 0, 1, 8'h44, 4, 6, 1);
        check("rmf_pending", {31'h0, bus.wr_pending}, 32'h0);
        cyc(0, 0, 0, 8'h00, 4, 6, 1);
        check("rmf_err", {31'h0, bus.wr_err}, 32'h1);
        check("rmf_r4", {24'h0, bus.rd_data_a}, 32'h00);
        check("rmf_r6_cleared", {24'h0, bus.rd_data_b}, 32'h00);

        // Random phase: strobe mostly aligned with the pipe, rare resets.
        for (int n = 0; n < 300; n++) begin
            logic en, rq, rb_n;
            rq   = ($urandom_range(0, 2) != 0);
            en   = m_v2 ^ ($urandom_range(0, 11) == 0);
            rb_n = ($urandom_range(0, 59) != 0);
            cyc(rq, 3'($urandom_range(0, 7)), en, 8'($urandom_range(0, 255)),
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), rb_n);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
